// File: rtl/yurut_denetim_pkg.sv
// Shared definitions for the execute-stage sequencer.
// Holds the op-code encoding, the sequencer state encoding and op-class
// decode helpers used by yurut_denetim and its testbench.
package yurut_denetim_pkg;

  localparam int unsigned ISLEM_W  = 6;
  localparam int unsigned YAZMAC_W = 5;

  // Op codes seen on islem_kodu_i; anything else is passed to the AMB as-is.
  typedef enum logic [ISLEM_W-1:0] {
    ISLEM_ADD  = 6'd0,
    ISLEM_SUB  = 6'd1,
    ISLEM_XOR  = 6'd4,
    ISLEM_JAL  = 6'd10,
    ISLEM_JALR = 6'd11,
    ISLEM_DIV  = 6'd16,
    ISLEM_DIVU = 6'd17,
    ISLEM_REM  = 6'd18,
    ISLEM_REMU = 6'd19
  } islem_e;

  typedef enum logic [2:0] {
    BOSTA     = 3'd0,
    AMB_BEKLE = 3'd1,
    BOLME     = 3'd2,
    DUZELT    = 3'd3,
    SONUC     = 3'd4
  } durum_e;

  // DIV-class decode: ops executed on the internal divider.
  function automatic logic bolme_mi(input logic [ISLEM_W-1:0] k);
    return k inside {ISLEM_DIV, ISLEM_DIVU, ISLEM_REM, ISLEM_REMU};
  endfunction

  function automatic logic isaretli_mi(input logic [ISLEM_W-1:0] k);
    return k inside {ISLEM_DIV, ISLEM_REM};
  endfunction

  function automatic logic kalan_mi(input logic [ISLEM_W-1:0] k);
    return k inside {ISLEM_REM, ISLEM_REMU};
  endfunction

  function automatic logic atlama_mi(input logic [ISLEM_W-1:0] k);
    return k inside {ISLEM_JAL, ISLEM_JALR};
  endfunction

endpackage

// File: rtl/yurut_denetim_bolme_birimi.sv
// Iterative restoring unsigned divider, BOLME_ADIM quotient bits per cycle.
// Ports: clk/rst_n, iptal (abandon run), basla (load operands),
//        bolunen/bolen (dividend/divisor), bolum/kalan (quotient/remainder),
//        bitti (high during the final iteration cycle; results valid next cycle).
module yurut_denetim_bolme_birimi #(
  parameter int unsigned VERI_W     = 32,
  parameter int unsigned BOLME_ADIM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iptal,
  input  logic              basla,
  input  logic [VERI_W-1:0] bolunen,
  input  logic [VERI_W-1:0] bolen,
  output logic [VERI_W-1:0] bolum,
  output logic [VERI_W-1:0] kalan,
  output logic              bitti
);

  localparam int unsigned ADIM_SAYISI = VERI_W / BOLME_ADIM;
  localparam int unsigned SAYAC_W     = $clog2(ADIM_SAYISI + 1);

  logic [VERI_W-1:0]  bolen_q;
  logic [SAYAC_W-1:0] sayac;
  logic [VERI_W-1:0]  bolum_d;
  logic [VERI_W-1:0]  kalan_d;
  logic [VERI_W:0]    genis;
  logic [VERI_W:0]    fark;

  // One cycle worth of shift/subtract steps; bolum doubles as the dividend shifter.
  always_comb begin
    bolum_d = bolum;
    kalan_d = kalan;
    genis   = '0;
    fark    = '0;
    for (int i = 0; i < int'(BOLME_ADIM); i++) begin
      genis   = {kalan_d, bolum_d[VERI_W-1]};
      bolum_d = {bolum_d[VERI_W-2:0], 1'b0};
      fark    = genis - {1'b0, bolen_q};
      if (!fark[VERI_W]) begin
        kalan_d    = fark[VERI_W-1:0];
        bolum_d[0] = 1'b1;
      end else begin
        kalan_d = genis[VERI_W-1:0];
      end
    end
  end

  // sayac counts remaining iterations; bitti flags the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bolum   <= '0;
      kalan   <= '0;
      bolen_q <= '0;
      sayac   <= '0;
      bitti   <= 1'b0;
    end else if (iptal) begin
      sayac <= '0;
      bitti <= 1'b0;
    end else if (basla) begin
      bolum   <= bolunen;
      kalan   <= '0;
      bolen_q <= bolen;
      sayac   <= SAYAC_W'(ADIM_SAYISI);
      bitti   <= (ADIM_SAYISI == 1);
    end else if (sayac != '0) begin
      bolum <= bolum_d;
      kalan <= kalan_d;
      sayac <= sayac - SAYAC_W'(1);
      bitti <= (sayac == SAYAC_W'(2));
    end else begin
      bitti <= 1'b0;
    end
  end

endmodule

// File: rtl/yurut_denetim.sv
// Execute-stage sequencer around the AMB: single-cycle ops go through the
// external AMB, DIV/DIVU/REM/REMU through the internal divider; the result is
// held until downstream accepts it. JAL/JALR raise a jump redirect.
// Ports: clk_i/rst_ni, temizle_i (flush), giris_* (op handshake + operands),
//        amb_* (AMB request / registered AMB result), cikis_* (result handshake),
//        sonuc_o/hedef_yazmac_o (result, rd), atlama_* (jump), mesgul_o (busy).
module yurut_denetim
  import yurut_denetim_pkg::*;
#(
  parameter int unsigned VERI_W     = 32,
  parameter int unsigned BOLME_ADIM = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                temizle_i,
  input  logic                giris_gecerli_i,
  output logic                giris_hazir_o,
  input  logic [ISLEM_W-1:0]  islem_kodu_i,
  input  logic [VERI_W-1:0]   yazmac_degeri1_i,
  input  logic [VERI_W-1:0]   yazmac_degeri2_i,
  input  logic [VERI_W-1:0]   anlik_i,
  input  logic [VERI_W-1:0]   adres_i,
  input  logic [YAZMAC_W-1:0] hedef_yazmac_i,
  output logic [ISLEM_W-1:0]  amb_islem_kodu_o,
  output logic [VERI_W-1:0]   amb_deger1_o,
  output logic [VERI_W-1:0]   amb_deger2_o,
  output logic [VERI_W-1:0]   amb_anlik_o,
  output logic [VERI_W-1:0]   amb_adres_o,
  input  logic [VERI_W-1:0]   amb_sonuc_i,
  input  logic [VERI_W-1:0]   amb_atlama_i,
  output logic                cikis_gecerli_o,
  input  logic                cikis_hazir_i,
  output logic [VERI_W-1:0]   sonuc_o,
  output logic [YAZMAC_W-1:0] hedef_yazmac_o,
  output logic                atlama_gecerli_o,
  output logic [VERI_W-1:0]   atlama_adres_o,
  output logic                mesgul_o
);

  localparam logic [VERI_W-1:0] EN_KUCUK = {1'b1, {(VERI_W-1){1'b0}}};

  durum_e                durum;
  logic [ISLEM_W-1:0]    islem_q;
  logic [VERI_W-1:0]     deger1_q, deger2_q, anlik_q, adres_q;
  logic [YAZMAC_W-1:0]   hedef_q;
  logic                  ozel_q, kalan_mi_q, bolum_neg_q, kalan_neg_q;
  logic [VERI_W-1:0]     ozel_sonuc_q;

  logic                  kabul;
  logic                  isaretli, a_neg, b_neg, sifir_bolen, tasma, ozel, bolme_basla;
  logic [VERI_W-1:0]     a_mag, b_mag, ozel_deger;
  logic [VERI_W-1:0]     bolum, kalan;
  logic                  bitti;
  durum_e                yeni_durum;

  // Ready is combinational so a held result can hand over to the next op without a bubble.
  assign giris_hazir_o = !temizle_i && ((durum == BOSTA) || ((durum == SONUC) && cikis_hazir_i));
  assign kabul         = giris_gecerli_i && giris_hazir_o;
  assign mesgul_o      = (durum != BOSTA);

  // AMB sees the live op during the accept cycle, the latched copy afterwards.
  assign amb_islem_kodu_o = kabul ? islem_kodu_i     : islem_q;
  assign amb_deger1_o     = kabul ? yazmac_degeri1_i : deger1_q;
  assign amb_deger2_o     = kabul ? yazmac_degeri2_i : deger2_q;
  assign amb_anlik_o      = kabul ? anlik_i          : anlik_q;
  assign amb_adres_o      = kabul ? adres_i          : adres_q;

  // Accept-time divide preparation: magnitudes, signs and the special cases.
  always_comb begin
    isaretli    = isaretli_mi(islem_kodu_i);
    a_neg       = isaretli && yazmac_degeri1_i[VERI_W-1];
    b_neg       = isaretli && yazmac_degeri2_i[VERI_W-1];
    a_mag       = a_neg ? (~yazmac_degeri1_i + VERI_W'(1)) : yazmac_degeri1_i;
    b_mag       = b_neg ? (~yazmac_degeri2_i + VERI_W'(1)) : yazmac_degeri2_i;
    sifir_bolen = (yazmac_degeri2_i == '0);
    tasma       = isaretli && (yazmac_degeri1_i == EN_KUCUK) && (yazmac_degeri2_i == '1);
    ozel        = bolme_mi(islem_kodu_i) && (sifir_bolen || tasma);
    if (sifir_bolen) begin
      ozel_deger = kalan_mi(islem_kodu_i) ? yazmac_degeri1_i : '1;
    end else begin
      ozel_deger = kalan_mi(islem_kodu_i) ? '0 : EN_KUCUK;
    end
    bolme_basla = kabul && bolme_mi(islem_kodu_i) && !ozel;
    yeni_durum  = (bolme_mi(islem_kodu_i) && !ozel) ? BOLME : AMB_BEKLE;
  end

  yurut_denetim_bolme_birimi #(
    .VERI_W     (VERI_W),
    .BOLME_ADIM (BOLME_ADIM)
  ) u_bolme (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .iptal   (temizle_i),
    .basla   (bolme_basla),
    .bolunen (a_mag),
    .bolen   (b_mag),
    .bolum   (bolum),
    .kalan   (kalan),
    .bitti   (bitti)
  );

  // Sequencer: op latching, state transitions and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum            <= BOSTA;
      islem_q          <= '0;
      deger1_q         <= '0;
      deger2_q         <= '0;
      anlik_q          <= '0;
      adres_q          <= '0;
      hedef_q          <= '0;
      ozel_q           <= 1'b0;
      ozel_sonuc_q     <= '0;
      kalan_mi_q       <= 1'b0;
      bolum_neg_q      <= 1'b0;
      kalan_neg_q      <= 1'b0;
      cikis_gecerli_o  <= 1'b0;
      sonuc_o          <= '0;
      hedef_yazmac_o   <= '0;
      atlama_gecerli_o <= 1'b0;
      atlama_adres_o   <= '0;
    end else if (temizle_i) begin
      durum            <= BOSTA;
      cikis_gecerli_o  <= 1'b0;
      atlama_gecerli_o <= 1'b0;
    end else begin
      if (kabul) begin
        islem_q      <= islem_kodu_i;
        deger1_q     <= yazmac_degeri1_i;
        deger2_q     <= yazmac_degeri2_i;
        anlik_q      <= anlik_i;
        adres_q      <= adres_i;
        hedef_q      <= hedef_yazmac_i;
        ozel_q       <= ozel;
        ozel_sonuc_q <= ozel_deger;
        kalan_mi_q   <= kalan_mi(islem_kodu_i);
        bolum_neg_q  <= a_neg ^ b_neg;
        kalan_neg_q  <= a_neg;
      end
      case (durum)
        BOSTA: begin
          if (kabul) durum <= yeni_durum;
        end
        AMB_BEKLE: begin
          sonuc_o          <= ozel_q ? ozel_sonuc_q : amb_sonuc_i;
          atlama_adres_o   <= amb_atlama_i;
          atlama_gecerli_o <= !ozel_q && atlama_mi(islem_q);
          hedef_yazmac_o   <= hedef_q;
          cikis_gecerli_o  <= 1'b1;
          durum            <= SONUC;
        end
        BOLME: begin
          if (bitti) durum <= DUZELT;
        end
        DUZELT: begin
          if (kalan_mi_q) begin
            sonuc_o <= kalan_neg_q ? (~kalan + VERI_W'(1)) : kalan;
          end else begin
            sonuc_o <= bolum_neg_q ? (~bolum + VERI_W'(1)) : bolum;
          end
          atlama_gecerli_o <= 1'b0;
          hedef_yazmac_o   <= hedef_q;
          cikis_gecerli_o  <= 1'b1;
          durum            <= SONUC;
        end
        SONUC: begin
          if (cikis_hazir_i) begin
            cikis_gecerli_o  <= 1'b0;
            atlama_gecerli_o <= 1'b0;
            durum            <= kabul ? yeni_durum : BOSTA;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_yurut_denetim.sv
// Self-checking bench for yurut_denetim: directed vector table, randomized ops
// against a reference model, and hand sequences for backpressure, flush and reset.
module tb_yurut_denetim;
  import yurut_denetim_pkg::*;

  localparam int unsigned W   = 32;
  localparam int          N   = 32;
  localparam int          DIV_LAT = N + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          temizle = 1'b0;
  logic          giris_gecerli = 1'b0;
  logic          giris_hazir;
  logic [5:0]    islem = '0;
  logic [W-1:0]  d1 = '0, d2 = '0, anlik = '0, adres = '0;
  logic [4:0]    rd = '0;
  logic [5:0]    amb_islem;
  logic [W-1:0]  amb_d1, amb_d2, amb_anlik, amb_adres;
  logic [W-1:0]  amb_sonuc = '0, amb_atlama = '0;
  logic          cikis_gecerli;
  logic          cikis_hazir = 1'b1;
  logic [W-1:0]  sonuc;
  logic [4:0]    hedef;
  logic          atlama_gecerli;
  logic [W-1:0]  atlama_adres;
  logic          mesgul;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  yurut_denetim #(.VERI_W(W), .BOLME_ADIM(1)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .temizle_i        (temizle),
    .giris_gecerli_i  (giris_gecerli),
    .giris_hazir_o    (giris_hazir),
    .islem_kodu_i     (islem),
    .yazmac_degeri1_i (d1),
    .yazmac_degeri2_i (d2),
    .anlik_i          (anlik),
    .adres_i          (adres),
    .hedef_yazmac_i   (rd),
    .amb_islem_kodu_o (amb_islem),
    .amb_deger1_o     (amb_d1),
    .amb_deger2_o     (amb_d2),
    .amb_anlik_o      (amb_anlik),
    .amb_adres_o      (amb_adres),
    .amb_sonuc_i      (amb_sonuc),
    .amb_atlama_i     (amb_atlama),
    .cikis_gecerli_o  (cikis_gecerli),
    .cikis_hazir_i    (cikis_hazir),
    .sonuc_o          (sonuc),
    .hedef_yazmac_o   (hedef),
    .atlama_gecerli_o (atlama_gecerli),
    .atlama_adres_o   (atlama_adres),
    .mesgul_o         (mesgul)
  );

  // Simple registered AMB; unknown ops yield a recognisable constant.
  always_ff @(posedge clk) begin
    case (amb_islem)
      ISLEM_ADD:  amb_sonuc <= amb_d1 + amb_d2;
      ISLEM_SUB:  amb_sonuc <= amb_d1 - amb_d2;
      ISLEM_XOR:  amb_sonuc <= amb_d1 ^ amb_d2;
      ISLEM_JAL, ISLEM_JALR: amb_sonuc <= amb_adres + 32'd4;
      default:    amb_sonuc <= 32'hDEAD_BEEF;
    endcase
    if (amb_islem == ISLEM_JALR) amb_atlama <= (amb_d1 + amb_anlik) & ~32'd1;
    else                         amb_atlama <= amb_adres + amb_anlik;
  end

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a, b, imm, pc;
    logic [4:0]   rd;
    logic [W-1:0] sonuc;
    int           lat;
    logic         atl;
    logic [W-1:0] atl_adr;
  } vec_t;

  function automatic vec_t v(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] imm, input logic [W-1:0] pc, input logic [4:0] r,
                             input logic [W-1:0] s, input int lat, input logic atl,
                             input logic [W-1:0] adr);
    vec_t x;
    x.op = op; x.a = a; x.b = b; x.imm = imm; x.pc = pc; x.rd = r;
    x.sonuc = s; x.lat = lat; x.atl = atl; x.atl_adr = adr;
    return x;
  endfunction

  // Reference model from the architectural rules.
  function automatic vec_t model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] imm, input logic [W-1:0] pc, input logic [4:0] r);
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] s, adr;
    logic ovf, div;
    int lat;
    sa = a; sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    div = op inside {ISLEM_DIV, ISLEM_DIVU, ISLEM_REM, ISLEM_REMU};
    adr = 32'h0;
    case (op)
      ISLEM_ADD:  s = a + b;
      ISLEM_SUB:  s = a - b;
      ISLEM_XOR:  s = a ^ b;
      ISLEM_JAL:  begin s = pc + 32'd4; adr = pc + imm; end
      ISLEM_JALR: begin s = pc + 32'd4; adr = (a + imm) & ~32'd1; end
      ISLEM_DIV:  s = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : W'(sa / sb);
      ISLEM_DIVU: s = (b == 0) ? 32'hFFFF_FFFF : a / b;
      ISLEM_REM:  s = (b == 0) ? a : ovf ? 32'h0 : W'(sa % sb);
      ISLEM_REMU: s = (b == 0) ? a : a % b;
      default:    s = 32'hDEAD_BEEF;
    endcase
    if (div && !(b == 0) && !(ovf && (op inside {ISLEM_DIV, ISLEM_REM}))) lat = DIV_LAT;
    else lat = 2;
    return v(op, a, b, imm, pc, r, s, lat, (op == ISLEM_JAL) || (op == ISLEM_JALR), adr);
  endfunction

  task automatic chk(input string ad, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", ad, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sur(input vec_t x);
    islem = x.op; d1 = x.a; d2 = x.b; anlik = x.imm; adres = x.pc; rd = x.rd;
  endtask

  task automatic karistir();
    islem = 6'($urandom); d1 = $urandom; d2 = $urandom; anlik = $urandom; adres = $urandom;
    rd = 5'($urandom);
  endtask

  // Issue one op from idle with downstream ready, and check its result and latency.
  task automatic run_op(input string ad, input vec_t x);
    int cnt;
    cnt = 0;
    sur(x);
    giris_gecerli = 1'b1;
    while (!giris_hazir && cnt < 100) begin tick(); cnt++; end
    if (!giris_hazir) chk({ad, "_accept_timeout"}, 32'(giris_hazir), 32'd1);
    tick();
    giris_gecerli = 1'b0;
    karistir();
    chk({ad, "_busy"}, 32'(mesgul), 32'd1);
    cnt = 1;
    while (!cikis_gecerli && cnt < 200) begin tick(); cnt++; end
    chk({ad, "_latency"}, W'(cnt), W'(x.lat));
    chk({ad, "_sonuc"}, sonuc, x.sonuc);
    chk({ad, "_rd"}, 32'(hedef), 32'(x.rd));
    chk({ad, "_atlama_gecerli"}, 32'(atlama_gecerli), 32'(x.atl));
    if (x.atl) chk({ad, "_atlama_adres"}, atlama_adres, x.atl_adr);
    tick();
    chk({ad, "_valid_drop"}, 32'(cikis_gecerli), 32'd0);
  endtask

  vec_t tablo[16];
  logic [5:0] ops[10];

  function automatic logic [W-1:0] rastgele();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    vec_t x;
    ops = '{ISLEM_ADD, ISLEM_SUB, ISLEM_XOR, ISLEM_JAL, ISLEM_JALR,
            ISLEM_DIV, ISLEM_DIVU, ISLEM_REM, ISLEM_REMU, 6'h3F};

    tablo[0]  = v(ISLEM_ADD,  32'd5,         32'd7,         32'd0,     32'd0,     5'd3,  32'd12,        2,       1'b0, 32'd0);
    tablo[1]  = v(ISLEM_DIV,  32'hFFFF_FFEC, 32'd3,         32'd0,     32'd0,     5'd7,  32'hFFFF_FFFA, DIV_LAT, 1'b0, 32'd0);
    tablo[2]  = v(ISLEM_REM,  32'hFFFF_FFEC, 32'd3,         32'd0,     32'd0,     5'd8,  32'hFFFF_FFFE, DIV_LAT, 1'b0, 32'd0);
    tablo[3]  = v(ISLEM_DIVU, 32'd9,         32'd0,         32'd0,     32'd0,     5'd9,  32'hFFFF_FFFF, 2,       1'b0, 32'd0);
    tablo[4]  = v(ISLEM_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,     32'd0,     5'd10, 32'd0,         2,       1'b0, 32'd0);
    tablo[5]  = v(ISLEM_JALR, 32'h100,       32'd0,         32'd8,     32'h40,    5'd1,  32'h44,        2,       1'b1, 32'h108);
    tablo[6]  = v(ISLEM_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,     32'd0,     5'd11, 32'h8000_0000, 2,       1'b0, 32'd0);
    tablo[7]  = v(ISLEM_REMU, 32'd9,         32'd0,         32'd0,     32'd0,     5'd12, 32'd9,         2,       1'b0, 32'd0);
    tablo[8]  = v(ISLEM_DIV,  32'd7,         32'd0,         32'd0,     32'd0,     5'd13, 32'hFFFF_FFFF, 2,       1'b0, 32'd0);
    tablo[9]  = v(ISLEM_REM,  32'hFFFF_FFFB, 32'd0,         32'd0,     32'd0,     5'd14, 32'hFFFF_FFFB, 2,       1'b0, 32'd0);
    tablo[10] = v(ISLEM_DIVU, 32'hFFFF_FFFF, 32'd1,         32'd0,     32'd0,     5'd15, 32'hFFFF_FFFF, DIV_LAT, 1'b0, 32'd0);
    tablo[11] = v(ISLEM_REMU, 32'd100,       32'd7,         32'd0,     32'd0,     5'd16, 32'd2,         DIV_LAT, 1'b0, 32'd0);
    tablo[12] = v(ISLEM_DIV,  32'd20,        32'hFFFF_FFFD, 32'd0,     32'd0,     5'd17, 32'hFFFF_FFFA, DIV_LAT, 1'b0, 32'd0);
    tablo[13] = v(ISLEM_REM,  32'd20,        32'hFFFF_FFFD, 32'd0,     32'd0,     5'd18, 32'd2,         DIV_LAT, 1'b0, 32'd0);
    tablo[14] = v(ISLEM_JAL,  32'd0,         32'd0,         32'h20,    32'h1000,  5'd19, 32'h1004,      2,       1'b1, 32'h1020);
    tablo[15] = v(6'h3F,      32'd1,         32'd2,         32'd0,     32'd0,     5'd20, 32'hDEAD_BEEF, 2,       1'b0, 32'd0);

    // Reset values
    repeat (3) tick();
    chk("rst_busy", 32'(mesgul), 32'd0);
    chk("rst_valid", 32'(cikis_gecerli), 32'd0);
    chk("rst_ready", 32'(giris_hazir), 32'd1);
    chk("rst_sonuc", sonuc, 32'd0);
    chk("rst_atlama", 32'(atlama_gecerli), 32'd0);
    chk("rst_rd", 32'(hedef), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), tablo[i]);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      x = model(ops[$urandom_range(0, 9)], rastgele(), rastgele(), $urandom, $urandom, 5'($urandom));
      run_op($sformatf("rnd%0d_op%0d", i, x.op), x);
    end

    // Backpressure: result frozen while downstream stalls, then back-to-back handover
    cikis_hazir = 1'b0;
    sur(v(ISLEM_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4, 32'd0, 0, 1'b0, 32'd0));
    giris_gecerli = 1'b1;
    tick();
    sur(v(ISLEM_XOR, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd9, 32'd0, 0, 1'b0, 32'd0));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), 32'(cikis_gecerli), 32'd1);
      chk($sformatf("stall%0d_sonuc", i), sonuc, 32'd3);
      chk($sformatf("stall%0d_rd", i), 32'(hedef), 32'd4);
      chk($sformatf("stall%0d_ready", i), 32'(giris_hazir), 32'd0);
      tick();
    end
    cikis_hazir = 1'b1;
    #1;
    chk("b2b_ready", 32'(giris_hazir), 32'd1);
    tick();
    giris_gecerli = 1'b0;
    chk("b2b_valid_low", 32'(cikis_gecerli), 32'd0);
    chk("b2b_busy", 32'(mesgul), 32'd1);
    tick();
    chk("b2b_valid", 32'(cikis_gecerli), 32'd1);
    chk("b2b_sonuc", sonuc, 32'hFF);
    chk("b2b_rd", 32'(hedef), 32'd9);
    tick();

    // Flush in BOLME cycle 10; an op presented alongside must be refused
    sur(v(ISLEM_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 5'd5, 32'd0, 0, 1'b0, 32'd0));
    giris_gecerli = 1'b1;
    tick();
    giris_gecerli = 1'b0;
    repeat (9) tick();
    temizle = 1'b1;
    sur(v(ISLEM_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd6, 32'd0, 0, 1'b0, 32'd0));
    giris_gecerli = 1'b1;
    #1;
    chk("flush_ready", 32'(giris_hazir), 32'd0);
    tick();
    temizle = 1'b0;
    giris_gecerli = 1'b0;
    chk("flush_idle", 32'(mesgul), 32'd0);
    chk("flush_valid", 32'(cikis_gecerli), 32'd0);
    seen = 0;
    repeat (40) begin tick(); if (cikis_gecerli || mesgul) seen++; end
    chk("flush_quiet", W'(seen), 32'd0);
    run_op("after_flush", tablo[11]);

    // Asynchronous reset mid-division
    sur(tablo[1]);
    giris_gecerli = 1'b1;
    tick();
    giris_gecerli = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(mesgul), 32'd0);
    chk("arst_sonuc", sonuc, 32'd0);
    chk("arst_rd", 32'(hedef), 32'd0);
    chk("arst_ready", 32'(giris_hazir), 32'd1);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin tick(); if (cikis_gecerli) seen++; end
    chk("arst_no_partial", W'(seen), 32'd0);
    run_op("after_reset", tablo[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
